// File: rtl/alu_flag_stage.sv
// Registered result/flag stage behind the integer ALU: computes NZCV on accept,
// buffers result+flags in a small valid/ready FIFO and keeps sticky C/V status.
module alu_flag_stage #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_result,
    input  logic                       in_cout,
    input  logic                       in_ovf,
    input  logic [1:0]                 in_ctrl,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_result,
    output logic                       out_z,
    output logic                       out_n,
    output logic                       out_c,
    output logic                       out_v,
    output logic                       sticky_c,
    output logic                       sticky_v,
    input  logic                       sticky_clr,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = WIDTH + 4;
    localparam logic [CW-1:0] DEPTH_C = DEPTH[CW-1:0];

    logic [EW-1:0] mem [DEPTH];

    logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0] count_reg, count_next;
    logic [EW-1:0] head_reg, head_next;
    logic          out_valid_reg, out_valid_next;
    logic          sticky_c_reg, sticky_c_next;
    logic          sticky_v_reg, sticky_v_next;

    logic          flag_z, flag_n, flag_c, flag_v;
    logic [EW-1:0] in_entry;
    logic          push, pop;

    // Logic ops (ctrl[1]=1) never report carry or overflow.
    assign flag_z   = (in_result == '0);
    assign flag_n   = in_result[WIDTH-1];
    assign flag_c   = in_cout & ~in_ctrl[1];
    assign flag_v   = in_ovf  & ~in_ctrl[1];
    assign in_entry = {in_result, flag_z, flag_n, flag_c, flag_v};

    assign in_ready = rst_n & (count_reg < DEPTH_C);
    assign push     = in_valid & in_ready;
    assign pop      = out_valid_reg & out_ready;

    always_comb begin
        wr_ptr_next    = wr_ptr_reg + {{(PW-1){1'b0}}, push};
        rd_ptr_next    = rd_ptr_reg + {{(PW-1){1'b0}}, pop};
        count_next     = count_reg + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
        out_valid_next = (count_next != '0);
        head_next      = head_reg;
        // The new head may be the slot written this very cycle: bypass the array.
        if (count_next != '0) begin
            if (push && (wr_ptr_reg == rd_ptr_next))
                head_next = in_entry;
            else
                head_next = mem[rd_ptr_next];
        end
    end

    always_comb begin
        sticky_c_next = sticky_clr ? 1'b0 : sticky_c_reg;
        sticky_v_next = sticky_clr ? 1'b0 : sticky_v_reg;
        if (push) begin
            sticky_c_next = sticky_c_next | flag_c;
            sticky_v_next = sticky_v_next | flag_v;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_reg] <= in_entry;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            head_reg      <= '0;
            out_valid_reg <= 1'b0;
            sticky_c_reg  <= 1'b0;
            sticky_v_reg  <= 1'b0;
        end else begin
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            count_reg     <= count_next;
            head_reg      <= head_next;
            out_valid_reg <= out_valid_next;
            sticky_c_reg  <= sticky_c_next;
            sticky_v_reg  <= sticky_v_next;
        end
    end

    assign out_valid  = out_valid_reg;
    assign out_result = head_reg[EW-1:4];
    assign out_z      = head_reg[3];
    assign out_n      = head_reg[2];
    assign out_c      = head_reg[1];
    assign out_v      = head_reg[0];
    assign sticky_c   = sticky_c_reg;
    assign sticky_v   = sticky_v_reg;
    assign count      = count_reg;

endmodule

// File: tb/tb_alu_flag_stage.sv
// Directed-vector bench for alu_flag_stage: each task drives one scenario and
// checks outputs 1ns after the rising edge against hand-computed values.
module tb_alu_flag_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_result;
    logic        in_cout;
    logic        in_ovf;
    logic [1:0]  in_ctrl;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_z, out_n, out_c, out_v;
    logic        sticky_c, sticky_v;
    logic        sticky_clr;
    logic [1:0]  count;

    int checks = 0;
    int fails  = 0;

    alu_flag_stage #(.WIDTH(32), .DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
        .in_cout(in_cout), .in_ovf(in_ovf), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_z(out_z), .out_n(out_n), .out_c(out_c), .out_v(out_v),
        .sticky_c(sticky_c), .sticky_v(sticky_v), .sticky_clr(sticky_clr),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] r, input logic co,
                         input logic ov, input logic [1:0] ctl);
        in_valid  = v;
        in_result = r;
        in_cout   = co;
        in_ovf    = ov;
        in_ctrl   = ctl;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; out_ready = 1'b0; sticky_clr = 1'b0;
        drive(1'b1, 32'h1234_5678, 1'b1, 1'b1, 2'b00);
        step(); step();
        checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL rst_in_ready: got %b expected 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
        checks++; if ({out_result, out_z, out_n, out_c, out_v} !== 36'h0) begin fails++; $display("FAIL rst_outputs: got %h/%b%b%b%b expected 0", out_result, out_z, out_n, out_c, out_v); end
        checks++; if ({sticky_c, sticky_v, count} !== 4'b0) begin fails++; $display("FAIL rst_sticky_count: got %b%b %0d expected 00 0", sticky_c, sticky_v, count); end
        in_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rel_in_ready: got %b expected 1", in_ready); end
        checks++; if (count !== 2'd0) begin fails++; $display("FAIL rel_count: got %0d expected 0", count); end
        $display("test_reset done");
    endtask

    task automatic test_add_ovf();
        out_ready = 1'b1;
        drive(1'b1, 32'h8000_0000, 1'b0, 1'b1, 2'b00);
        step();
        checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL add_valid: got %b expected 1", out_valid); end
        checks++; if (out_result !== 32'h8000_0000) begin fails++; $display("FAIL add_result: got %h expected 80000000", out_result); end
        checks++; if ({out_z, out_n, out_c, out_v} !== 4'b0101) begin fails++; $display("FAIL add_flags: got %b expected 0101", {out_z, out_n, out_c, out_v}); end
        checks++; if (sticky_v !== 1'b1) begin fails++; $display("FAIL add_sticky_v: got %b expected 1", sticky_v); end
        $display("test_add_ovf done");
    endtask

    task automatic test_sub_logic();
        drive(1'b1, 32'h0, 1'b1, 1'b0, 2'b01);
        step();
        checks++; if ({out_z, out_n, out_c, out_v} !== 4'b1010) begin fails++; $display("FAIL sub_flags: got %b expected 1010", {out_z, out_n, out_c, out_v}); end
        checks++; if (count !== 2'd1) begin fails++; $display("FAIL sub_count: got %0d expected 1", count); end
        drive(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1, 2'b10);
        step();
        checks++; if (out_result !== 32'hFFFF_FFFF) begin fails++; $display("FAIL and_result: got %h expected ffffffff", out_result); end
        checks++; if ({out_z, out_n, out_c, out_v} !== 4'b0100) begin fails++; $display("FAIL and_flags: got %b expected 0100", {out_z, out_n, out_c, out_v}); end
        in_valid = 1'b0;
        step();
        checks++; if ({out_valid, count} !== 3'b000) begin fails++; $display("FAIL empty_state: got %b/%0d expected 0/0", out_valid, count); end
        checks++; if (out_result !== 32'hFFFF_FFFF) begin fails++; $display("FAIL empty_hold: got %h expected ffffffff", out_result); end
        checks++; if ({sticky_c, sticky_v} !== 2'b11) begin fails++; $display("FAIL sticky_accum: got %b expected 11", {sticky_c, sticky_v}); end
        $display("test_sub_logic done");
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(1'b1, 32'd1, 1'b0, 1'b0, 2'b10);
        step();
        checks++; if ({count, out_result} !== {2'd1, 32'd1}) begin fails++; $display("FAIL bp_first: got %0d/%h expected 1/1", count, out_result); end
        in_result = 32'd2;
        step();
        checks++; if ({count, in_ready} !== {2'd2, 1'b0}) begin fails++; $display("FAIL bp_full: got %0d/%b expected 2/0", count, in_ready); end
        in_result = 32'd3;
        step();
        checks++; if ({count, out_result} !== {2'd2, 32'd1}) begin fails++; $display("FAIL bp_hold: got %0d/%h expected 2/1", count, out_result); end
        out_ready = 1'b1;
        step();
        checks++; if ({count, out_result} !== {2'd1, 32'd2}) begin fails++; $display("FAIL bp_drain2: got %0d/%h expected 1/2", count, out_result); end
        step();
        checks++; if ({count, out_result} !== {2'd1, 32'd3}) begin fails++; $display("FAIL bp_third: got %0d/%h expected 1/3", count, out_result); end
        in_valid = 1'b0;
        step();
        checks++; if ({out_valid, count} !== 3'b000) begin fails++; $display("FAIL bp_empty: got %b/%0d expected 0/0", out_valid, count); end
        $display("test_backpressure done");
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        drive(1'b1, 32'hA, 1'b0, 1'b0, 2'b11);
        step();
        out_ready = 1'b1;
        in_result = 32'hB;
        step();
        checks++; if ({count, out_result} !== {2'd1, 32'hB}) begin fails++; $display("FAIL b2b_1: got %0d/%h expected 1/b", count, out_result); end
        in_result = 32'hC;
        step();
        checks++; if ({count, out_result} !== {2'd1, 32'hC}) begin fails++; $display("FAIL b2b_2: got %0d/%h expected 1/c", count, out_result); end
        in_valid = 1'b0;
        step();
        checks++; if (count !== 2'd0) begin fails++; $display("FAIL b2b_empty: got %0d expected 0", count); end
        $display("test_back_to_back done");
    endtask

    task automatic test_sticky();
        sticky_clr = 1'b1;
        drive(1'b1, 32'd5, 1'b0, 1'b1, 2'b00);
        step();
        checks++; if ({sticky_c, sticky_v} !== 2'b01) begin fails++; $display("FAIL sticky_set_wins: got %b expected 01", {sticky_c, sticky_v}); end
        in_valid = 1'b0;
        step();
        checks++; if ({sticky_c, sticky_v} !== 2'b00) begin fails++; $display("FAIL sticky_clear: got %b expected 00", {sticky_c, sticky_v}); end
        sticky_clr = 1'b0;
        step();
        $display("test_sticky done");
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        drive(1'b1, 32'h11, 1'b0, 1'b0, 2'b10);
        step();
        in_result = 32'h22;
        step();
        checks++; if (count !== 2'd2) begin fails++; $display("FAIL mid_fill: got %0d expected 2", count); end
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({out_valid, count, in_ready} !== 4'b0000) begin fails++; $display("FAIL mid_reset: got %b/%0d/%b expected 0/0/0", out_valid, count, in_ready); end
        checks++; if (out_result !== 32'h0) begin fails++; $display("FAIL mid_reset_result: got %h expected 0", out_result); end
        step();
        rst_n = 1'b1;
        drive(1'b1, 32'h1234, 1'b0, 1'b0, 2'b11);
        step();
        checks++; if ({out_valid, count, out_result} !== {1'b1, 2'd1, 32'h1234}) begin fails++; $display("FAIL post_reset_push: got %b/%0d/%h expected 1/1/1234", out_valid, count, out_result); end
        in_valid = 1'b0;
        step();
        $display("test_reset_mid done");
    endtask

    initial begin
        test_reset();
        test_add_ovf();
        test_sub_logic();
        test_backpressure();
        test_back_to_back();
        test_sticky();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/alu_flag_stage.md
Name: alu_flag_stage

Overview:
- Registered output stage directly downstream of the 32-bit integer ALU built from 1-bit slices.
- Captures the ALU word result plus the raw carry-out and overflow from the MSB slice, and computes architectural NZCV flags over the full word.
- Buffers result+flags in a small valid/ready FIFO so the FP datapath (exponent/mantissa consumers) can stall without losing ALU results.
- Maintains sticky carry/overflow status.

Parameters:
- WIDTH, 32, ALU word width; MSB is the sign bit.
- DEPTH, 2, FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  ALU result valid
- in_ready  out  1  stage can accept this cycle
- in_result  in  WIDTH  ALU word result
- in_cout  in  1  raw carry-out of MSB slice
- in_ovf  in  1  raw signed overflow from MSB slice
- in_ctrl  in  2  ALU op: 00 add, 01 sub, 10 and, 11 or
- out_valid  out  1  head entry valid
- out_ready  in  1  consumer accepts head
- out_result  out  WIDTH  head result
- out_z  out  1  zero flag
- out_n  out  1  negative flag
- out_c  out  1  carry flag
- out_v  out  1  overflow flag
- sticky_c  out  1  OR of accepted C flags since last clear
- sticky_v  out  1  OR of accepted V flags since last clear
- sticky_clr  in  1  synchronous clear of sticky flags
- count  out  $clog2(DEPTH)+1  occupied entries

Behaviour:
- Reset (rst_n low, asynchronous): FIFO empty, count=0, out_valid=0, out_result=0, out_z/n/c/v=0, sticky_c=sticky_v=0, read/write pointers=0. in_ready is forced 0 while rst_n is low.
- Reset asserted mid-operation: all buffered entries are discarded immediately. There is no partial drain.
- Flag computation, on accept, from the input cycle values:
  - Z = (in_result == 0).
  - N = in_result[WIDTH-1].
  - C = in_cout & ~in_ctrl[1]. Logic ops force C=0.
  - V = in_ovf & ~in_ctrl[1]. Logic ops force V=0.
  - Subtract convention: C=1 means no borrow.
- Accept when in_valid & in_ready. in_ready = (count < DEPTH) when out of reset; it is combinational from count only and never depends on out_ready.
- Pop when out_valid & out_ready.
- Latency: an entry accepted at edge k is visible at out_* immediately after edge k, when the FIFO was empty (1-cycle latency).
- Ordering: strict FIFO.
- Hold: while out_valid & ~out_ready, out_result and the out flags are stable.
- Empty: out_valid=0. out_result and flags hold their last popped values, not X.
- Full: count=DEPTH and in_ready=0. in_valid is ignored; the upstream ALU holds its operands.
- Simultaneous push and pop (count between 1 and DEPTH-1): count unchanged; head advances; new entry is appended at the tail.
- Pointers wrap modulo DEPTH. count saturates at 0 and DEPTH by construction.
- Sticky flags update on accept:
  - sticky_c |= C, sticky_v |= V.
  - sticky_clr clears both on the next edge.
  - If sticky_clr and a setting accept occur in the same cycle, the set wins (result 1).
  - Sticky flags are not affected by pops.
- No internal state machine beyond the FIFO occupancy (EMPTY / PARTIAL / FULL derived from count).

Test Plan:
- Reset: rst_n=0 with in_valid=1 → in_ready=0, out_valid=0, all outputs 0. Release reset → in_ready=1, count=0.
- Add overflow: in_result=0x80000000, in_cout=0, in_ovf=1, ctrl=00, out_ready=1 → next cycle out_valid=1, N=1, Z=0, C=0, V=1, sticky_v=1.
- Sub equal: in_result=0x00000000, cout=1, ovf=0, ctrl=01 → Z=1, N=0, C=1, V=0. Then ctrl=10 with cout=1, ovf=1, result=0xFFFFFFFF → Z=0, N=1, C=0, V=0.
- Backpressure: out_ready=0, push results 1, 2, 3 on consecutive cycles → 1 and 2 accepted, in_ready=0 after the second, count=2, out_result holds 1. Raise out_ready → outputs 1 then 2 in order; 3 accepted once a slot frees.
- Simultaneous push/pop at count=1 → count stays 1, order preserved. sticky_clr coincident with an accept having V=1 → sticky_v=1. sticky_clr alone → sticky_v=0.
- Reset mid-stream with count=2 → immediate empty, out_valid=0. Post-reset, the first push appears with 1-cycle latency.
